// File: rtl/mantissa_divider_pkg.sv
// Shared definitions for the mantissa divider slice: operand/quotient widths,
// counter width and the FSM state type.
//   MAN_W : mantissa width including the hidden bit
//   Q_W   : quotient width (1 integer bit, MAN_W fraction bits, 1 guard bit)
//   CNT_W : width of the quotient-bit counter
package mantissa_divider_pkg;

  localparam int MAN_W = 24;
  localparam int Q_W   = MAN_W + 2;
  localparam int CNT_W = $clog2(Q_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mandiv_state_t;

endpackage

// File: rtl/mantissa_divider_if.sv
// Operand/result handshake bundle for the mantissa divider.
//   in_valid/in_ready   : operand handshake (A_m dividend, B_m divisor)
//   out_valid/out_ready : result handshake (Q_m quotient, sticky, div_zero)
// master modport: the side supplying operands and consuming results.
// slave modport : the divider itself.
interface mantissa_divider_if;
  import mantissa_divider_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [MAN_W-1:0] A_m;
  logic [MAN_W-1:0] B_m;
  logic             out_valid;
  logic             out_ready;
  logic [Q_W-1:0]   Q_m;
  logic             sticky;
  logic             div_zero;

  modport master (
    output in_valid, A_m, B_m, out_ready,
    input  in_ready, out_valid, Q_m, sticky, div_zero
  );

  modport slave (
    input  in_valid, A_m, B_m, out_ready,
    output in_ready, out_valid, Q_m, sticky, div_zero
  );

endinterface

// File: rtl/mantissa_divider_step.sv
// One radix-2 restoring division step, purely combinational.
//   rem      : current partial remainder (MAN_W+1 bits)
//   div      : divisor mantissa
//   q_bit    : quotient bit produced by this step
//   rem_next : remainder after the conditional subtract (before the shift)
module mantissa_divider_step
  import mantissa_divider_pkg::*;
(
  input  logic [MAN_W:0]   rem,
  input  logic [MAN_W-1:0] div,
  output logic             q_bit,
  output logic [MAN_W:0]   rem_next
);

  logic [MAN_W:0] div_ext;

  assign div_ext  = {1'b0, div};
  assign q_bit    = (rem >= div_ext);
  assign rem_next = q_bit ? (rem - div_ext) : rem;

endmodule

// File: rtl/mantissa_divider.sv
// Iterative restoring divider for normalized FP mantissas, one quotient bit
// per clock. Produces Q_m = floor(A_m * 2^(Q_W-1) / B_m) plus a sticky bit
// flagging a nonzero final remainder.
//   clk : clock, rising edge
//   rst : synchronous reset, active high
//   bus : mantissa_divider_if.slave (operand and result handshakes)
// Optional feature macro MANDIV_EARLY_TERM_EN: when defined, the divide stops
// as soon as the remainder becomes zero (remaining quotient bits are zero),
// shortening latency; results are identical to the fixed-latency build.
module mantissa_divider
  import mantissa_divider_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  mantissa_divider_if.slave    bus
);

  mandiv_state_t    state_q;
  logic [MAN_W-1:0] b_q;
  logic [MAN_W:0]   rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic [Q_W-1:0]   quo_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [Q_W-1:0]   q_m_q;
  logic             sticky_q;
  logic             div_zero_q;

  logic             q_bit;
  logic [MAN_W:0]   rem_next;
  logic [Q_W-1:0]   quo_next;
  logic             early_stop;

  mantissa_divider_step u_step (
    .rem      (rem_q),
    .div      (b_q),
    .q_bit    (q_bit),
    .rem_next (rem_next)
  );

  assign quo_next = {quo_q[Q_W-2:0], q_bit};

`ifdef MANDIV_EARLY_TERM_EN
  assign early_stop = (rem_next == '0);
`else
  assign early_stop = 1'b0;
`endif

  // Control FSM plus datapath registers. Quotient bits are shifted in from
  // the LSB; on an early stop the partial quotient is shifted up by the
  // number of bits still outstanding (those bits are all zero). On the
  // normal last step cnt_q is zero, so the same expression applies.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      b_q         <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quo_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      q_m_q       <= '0;
      sticky_q    <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            b_q        <= bus.B_m;
            rem_q      <= {1'b0, bus.A_m};
            cnt_q      <= CNT_W'(Q_W - 1);
            quo_q      <= '0;
            in_ready_q <= 1'b0;
            if (bus.B_m == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              q_m_q       <= '1;
              sticky_q    <= 1'b0;
              div_zero_q  <= 1'b1;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_next << 1;
          quo_q <= quo_next;
          cnt_q <= cnt_q - 1'b1;
          if ((cnt_q == '0) || early_stop) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            q_m_q       <= quo_next << cnt_q;
            sticky_q    <= (rem_next != '0);
            div_zero_q  <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Q_m       = q_m_q;
  assign bus.sticky    = sticky_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_mantissa_divider.sv
// Self-checking bench for mantissa_divider: directed corner cases, a stalled
// result with ignored operand pulses, a mid-divide reset, then randomized
// normalized operands checked against an arithmetic reference.
// Honours MANDIV_EARLY_TERM_EN for the expected latency.
module tb_mantissa_divider;
  import mantissa_divider_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mantissa_divider_if bus ();

  mantissa_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: quotient and remainder from plain integer arithmetic. Latency
  // counts the accept edge as clock 1; with early termination the divide
  // ends after the first step j whose remainder A*2^(j-1) mod B is zero.
  task automatic refModel(input logic [23:0] a, input logic [23:0] b,
                          output logic [25:0] q, output logic s,
                          output logic dz, output int lat);
    longint unsigned num;
    longint unsigned den;
    bit found;
    if (b == 24'd0) begin
      q   = '1;
      s   = 1'b0;
      dz  = 1'b1;
      lat = 1;
    end else begin
      num = {40'd0, a} << 25;
      den = {40'd0, b};
      q   = 26'(num / den);
      s   = ((num % den) != 64'd0);
      dz  = 1'b0;
      lat = 27;
`ifdef MANDIV_EARLY_TERM_EN
      found = 1'b0;
      for (int j = 1; j <= 26; j++) begin
        if (!found && ((({40'd0, a} << (j - 1)) % den) == 64'd0)) begin
          found = 1'b1;
          lat   = j + 1;
        end
      end
`else
      found = 1'b0;
`endif
    end
  endtask

  // One full transaction: wait for idle, present operands for one cycle,
  // measure latency, check the result, optionally stall in DONE (with
  // ignored operand pulses), then release and check the return to idle.
  task automatic applyStimulus(input logic [23:0] a, input logic [23:0] b,
                               input int stall, input bit pulse);
    logic [25:0] eq;
    logic        es;
    logic        ed;
    int          elat;
    int          lat;
    int          w;
    refModel(a, b, eq, es, ed, elat);
    w = 0;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    checkOutput("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.A_m       = a;
    bus.B_m       = b;
    bus.out_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checkOutput("latency", 64'(lat), 64'(elat));
    checkOutput("Q_m", 64'(bus.Q_m), 64'(eq));
    checkOutput("sticky", 64'(bus.sticky), 64'(es));
    checkOutput("div_zero", 64'(bus.div_zero), 64'(ed));
    checkOutput("in_ready_busy", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < stall; i++) begin
      if (pulse) begin
        bus.in_valid = 1'b1;
        bus.A_m      = 24'($urandom);
        bus.B_m      = 24'($urandom);
      end
      @(negedge clk);
      checkOutput("stall_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("stall_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("stall_Q_m", 64'(bus.Q_m), 64'(eq));
      checkOutput("stall_sticky", 64'(bus.sticky), 64'(es));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput("release_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("release_ready", 64'(bus.in_ready), 64'd1);
  endtask

  // Main sequence.
  initial begin
    logic [23:0] ra;
    logic [23:0] rb;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A_m       = '0;
    bus.B_m       = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_Q_m", 64'(bus.Q_m), 64'd0);
    checkOutput("rst_sticky", 64'(bus.sticky), 64'd0);
    checkOutput("rst_div_zero", 64'(bus.div_zero), 64'd0);

    $display("[TB] directed operands");
    applyStimulus(24'hC00000, 24'h800000, 0, 1'b0);
    applyStimulus(24'h800000, 24'hC00000, 0, 1'b0);
    applyStimulus(24'hFFFFFF, 24'h800000, 0, 1'b0);
    applyStimulus(24'h800000, 24'hFFFFFF, 0, 1'b0);
    applyStimulus(24'h900000, 24'h000000, 0, 1'b0);

    $display("[TB] back-pressure with ignored operand pulses");
    applyStimulus(24'hA00000, 24'hE00000, 10, 1'b1);
    applyStimulus(24'hC00000, 24'h800000, 0, 1'b0);

    $display("[TB] reset during divide");
    bus.in_valid = 1'b1;
    bus.A_m      = 24'h800000;
    bus.B_m      = 24'hC00000;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("abort_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("abort_Q_m", 64'(bus.Q_m), 64'd0);
    applyStimulus(24'hFFFFFF, 24'h800000, 0, 1'b0);

    $display("[TB] randomized operands");
    for (int n = 0; n < 1500; n++) begin
      ra = 24'h800000 | 24'($urandom_range(24'h7FFFFF, 0));
      rb = 24'h800000 | 24'($urandom_range(24'h7FFFFF, 0));
      if ($urandom_range(49, 0) == 0) rb = 24'd0;
      applyStimulus(ra, rb, int'($urandom_range(3, 0)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
